// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF/LS) and memory-side signals around mem_port_arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        bus_err;
  logic        busy;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output ls_ack, ls_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output bus_err, busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  ls_ack, ls_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  bus_err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: arbitrates,
// runs one transaction at a time with a ready timeout, and returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned    CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic          last_ls_q, last_ls_d;
  logic          grant_ls_q, grant_ls_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          ls_ack_q, ls_ack_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          busy_q, busy_d;

  logic          ls_aligned;
  logic          pick_ls;

  always_comb begin
    unique case (bus.ls_size)
      2'b00:   ls_aligned = 1'b1;
      2'b01:   ls_aligned = ~bus.ls_addr[0];
      2'b10:   ls_aligned = (bus.ls_addr[1:0] == 2'b00);
      default: ls_aligned = 1'b0;
    endcase
  end

  // Round-robin only under contention; a lone requester never flips the priority.
  assign pick_ls = bus.ls_req & (~bus.if_req | ~last_ls_q);

  always_comb begin
    state_d     = state_q;
    last_ls_d   = last_ls_q;
    grant_ls_d  = grant_ls_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = '0;
    ls_rdata_d  = '0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req | bus.ls_req) begin
          if (bus.if_req & bus.ls_req) begin
            last_ls_d = pick_ls;
          end
          grant_ls_d = pick_ls;
          cnt_d      = '0;
          if (pick_ls) begin
            if (ls_aligned) begin
              mem_req_d   = 1'b1;
              mem_we_d    = bus.ls_we;
              mem_size_d  = bus.ls_size;
              mem_addr_d  = bus.ls_addr;
              mem_wdata_d = bus.ls_wdata;
              state_d     = BUSY;
            end else begin
              ls_ack_d  = 1'b1;
              bus_err_d = 1'b1;
              state_d   = RESP;
            end
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_size_d  = 2'b10;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            state_d     = BUSY;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (grant_ls_q) begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = RESP;
          if (grant_ls_q) begin
            ls_ack_d = 1'b1;
          end else begin
            if_ack_d = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_ls_q   <= 1'b0;
      grant_ls_q  <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ls_q   <= last_ls_d;
      grant_ls_q  <= grant_ls_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      bus_err_q   <= bus_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.busy      = busy_q;

endmodule
